// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge
// AHB-Lite slave that forwards each accepted transfer to one APB3 segment.
// Only one APB access is in flight at a time. A stuck pready is aborted after
// TIMEOUT ACCESS cycles. AHB errors use the two-cycle ERROR response.
//
// Ports
//   hclk, hresetn         clock, asynchronous active-low reset
//   hsel, haddr, htrans,  AHB-Lite address phase from the decoder
//   hwrite, hsize, hready
//   hwdata                AHB write data (data phase)
//   hready_out, hresp,    response back to the decoder's hready mux
//   hrdata
//   paddr, psel, penable, APB3 master side
//   pwrite, pwdata
//   prdata, pready,       APB3 completer response
//   pslverr
//
// state  | meaning
// IDLE   | no transfer in data phase, zero-wait OKAY
// WDATA  | write data phase, capturing hwdata into pwdata
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready or timeout
// ERR1   | first ERROR cycle (hready_out=0)
// ERR2   | second ERROR cycle (hready_out=1), may accept the next transfer
module ahb2apb_bridge #(
  parameter int PADDR_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               hsel,
  input  logic [31:0]        haddr,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic [2:0]         hsize,
  input  logic [31:0]        hwdata,
  input  logic               hready,
  output logic               hready_out,
  output logic               hresp,
  output logic [31:0]        hrdata,
  output logic [PADDR_W-1:0] paddr,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [31:0]        pwdata,
  input  logic [31:0]        prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t             state, state_nxt, dispatch;
  logic [CNT_W-1:0]   cnt, cnt_inc;
  logic               take, size_ok, done_ok, timeout_hit;
  logic               unused_bits;

  assign unused_bits = ^{haddr[31:PADDR_W], htrans[0]};

  // The slave can only take a new address phase while it is itself
  // signalling ready, so hready_out doubles as the "can accept" qualifier.
  assign take        = hsel & htrans[1] & hready & hready_out;
  assign size_ok     = (hsize <= 3'd2);
  assign done_ok     = (state == ACCESS) & pready & ~pslverr;
  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));
  assign dispatch    = !size_ok ? ERR1 : (hwrite ? WDATA : SETUP);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hready_out = 1'b0;
    hresp      = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    hrdata     = 32'h0;
    case (state)
      IDLE: begin
        hready_out = 1'b1;
        if (take) state_nxt = dispatch;
      end
      WDATA: state_nxt = SETUP;
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          if (pslverr) begin
            state_nxt = ERR1;
          end else begin
            hready_out = 1'b1;
            if (!pwrite) hrdata = prdata;
            state_nxt = take ? dispatch : IDLE;
          end
        end else if (timeout_hit) begin
          state_nxt = ERR1;
        end
      end
      ERR1: begin
        hresp     = 1'b1;
        state_nxt = ERR2;
      end
      ERR2: begin
        hresp      = 1'b1;
        hready_out = 1'b1;
        state_nxt  = take ? dispatch : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cnt <= '0;
    end else if (state_nxt == SETUP) begin
      cnt <= '0;
    end else if (state == ACCESS) begin
      cnt <= cnt_inc;
    end
  end

  // Oversized requests never reach APB, so they leave paddr/pwrite untouched.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      paddr  <= '0;
      pwrite <= 1'b0;
    end else if (take && size_ok) begin
      paddr  <= haddr[PADDR_W-1:0];
      pwrite <= hwrite;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pwdata <= 32'h0;
    end else if (state == WDATA) begin
      pwdata <= hwdata;
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Bench for ahb2apb_bridge: directed and random AHB transfers, with a
// per-transfer expected cycle list derived from the bridge's timing rules.
module tb_ahb2apb_bridge;
  localparam int PADDR_W = 16;
  localparam int TIMEOUT = 4;

  logic               hclk = 1'b0;
  logic               hresetn;
  logic               hsel;
  logic [31:0]        haddr;
  logic [1:0]         htrans;
  logic               hwrite;
  logic [2:0]         hsize;
  logic [31:0]        hwdata;
  logic               hready;
  logic               hready_out;
  logic               hresp;
  logic [31:0]        hrdata;
  logic [PADDR_W-1:0] paddr;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [31:0]        pwdata;
  logic [31:0]        prdata;
  logic               pready;
  logic               pslverr;
  logic               other_stall;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 hclk = ~hclk;

  // Bus-wide hready: this slave's ready, optionally held low by another slave.
  assign hready = hready_out & ~other_stall;

  ahb2apb_bridge #(.PADDR_W(PADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hready(hready), .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        err;
    logic        b2b;
  } xfer_t;

  typedef struct {
    logic        ro;
    logic        resp;
    logic        psel;
    logic        pen;
    logic [31:0] rd;
    logic        pr;
    logic        se;
    logic        dc;
  } cyc_t;

  xfer_t xq[$];
  cyc_t  exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic cyc_t mk(input logic ro, input logic resp, input logic ps,
                              input logic pen, input logic [31:0] rd,
                              input logic pr, input logic se, input logic dc);
    cyc_t c;
    c.ro = ro; c.resp = resp; c.psel = ps; c.pen = pen;
    c.rd = rd; c.pr = pr; c.se = se; c.dc = dc;
    return c;
  endfunction

  function automatic xfer_t mkx(input logic wr, input logic [31:0] addr,
                                input logic [2:0] size, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int waits,
                                input logic err, input logic b2b);
    xfer_t t;
    t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata;
    t.rdata = rdata; t.waits = waits; t.err = err; t.b2b = b2b;
    return t;
  endfunction

  // Expected data-phase cycles of one transfer, straight from the rules:
  // optional write-data cycle, one setup cycle, access cycles until pready
  // or timeout, then either OKAY completion or the two-cycle ERROR pair.
  task automatic build(input xfer_t t);
    int nw;
    exp_q.delete();
    if (t.size > 3'd2) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
      return;
    end
    if (t.wr) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
    nw = (t.waits >= TIMEOUT) ? TIMEOUT : t.waits;
    for (int i = 0; i < nw; i++)
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0));
    if (t.waits < TIMEOUT) begin
      if (t.err)
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0));
      else
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, t.wr ? 32'h0 : t.rdata, 1'b1, 1'b0, 1'b0));
    end
    if (t.waits >= TIMEOUT || t.err) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
    end
  endtask

  task automatic drive_addr(input xfer_t t);
    hsel = 1'b1; haddr = t.addr; htrans = 2'b10; hwrite = t.wr; hsize = t.size;
  endtask

  // Non-transfer address phase: deselected, IDLE or BUSY, with random noise.
  task automatic drive_idle();
    hsel   = 1'($urandom_range(0, 1));
    htrans = {1'b0, 1'($urandom_range(0, 1))};
    haddr  = $urandom;
    hwrite = 1'($urandom_range(0, 1));
    hsize  = 3'($urandom_range(0, 7));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hready_out"}, {31'h0, hready_out}, 32'h1);
    check({tag, "_hresp"},      {31'h0, hresp},      32'h0);
    check({tag, "_psel"},       {31'h0, psel},       32'h0);
    check({tag, "_penable"},    {31'h0, penable},    32'h0);
    check({tag, "_hrdata"},     hrdata,              32'h0);
  endtask

  task automatic check_reset(input string tag);
    check_idle(tag);
    check({tag, "_pwrite"}, {31'h0, pwrite}, 32'h0);
    check({tag, "_paddr"},  {16'h0, paddr},  32'h0);
    check({tag, "_pwdata"}, pwdata,          32'h0);
  endtask

  task automatic check_cycle(input cyc_t c, input xfer_t t, input int k);
    string tg;
    tg = $sformatf("a%h_c%0d", t.addr, k);
    check({tg, "_hready_out"}, {31'h0, hready_out}, {31'h0, c.ro});
    check({tg, "_hresp"},      {31'h0, hresp},      {31'h0, c.resp});
    check({tg, "_psel"},       {31'h0, psel},       {31'h0, c.psel});
    check({tg, "_penable"},    {31'h0, penable},    {31'h0, c.pen});
    check({tg, "_hrdata"},     hrdata,              c.rd);
    if (c.psel) begin
      check({tg, "_paddr"},  {16'h0, paddr},  {16'h0, t.addr[15:0]});
      check({tg, "_pwrite"}, {31'h0, pwrite}, {31'h0, t.wr});
      if (t.wr) check({tg, "_pwdata"}, pwdata, t.wdata);
    end
  endtask

  task automatic run_queue();
    xfer_t t;
    cyc_t  c;
    for (int i = 0; i < xq.size(); i++) begin
      t = xq[i];
      if (i == 0 || !xq[i-1].b2b) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge hclk); #1;
          drive_addr(t); other_stall = 1'b1;
          pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1));
          @(negedge hclk); check_idle("stalled_idle");
        end
        @(posedge hclk); #1;
        drive_addr(t); other_stall = 1'b0;
        pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1));
        @(negedge hclk); check_idle("pre_idle");
      end
      build(t);
      for (int k = 0; k < exp_q.size(); k++) begin
        c = exp_q[k];
        @(posedge hclk); #1;
        other_stall = 1'b0;
        hwdata  = t.wdata;
        prdata  = t.rdata;
        pready  = c.dc ? 1'($urandom_range(0, 1)) : c.pr;
        pslverr = c.pr ? c.se : 1'($urandom_range(0, 1));
        if (i + 1 < xq.size() && t.b2b) drive_addr(xq[i+1]);
        else drive_idle();
        @(negedge hclk); check_cycle(c, t, k);
      end
    end
    xq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    hresetn = 1'b0; other_stall = 1'b0;
    hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
    hwdata = 32'h0; prdata = 32'hA5A5_5A5A; pready = 1'b0; pslverr = 1'b0;
    #1 check_reset("reset");
    #11 hresetn = 1'b1;

    // Directed: read, waited write, slverr read, timeout, back-to-back chain.
    xq.push_back(mkx(1'b0, 32'h0000_0124, 3'd2, 32'h0,         32'hDEADBEEF, 0,  1'b0, 1'b0));
    xq.push_back(mkx(1'b1, 32'h0000_0200, 3'd2, 32'h12345678, 32'h0,        3,  1'b0, 1'b0));
    xq.push_back(mkx(1'b0, 32'h0000_0300, 3'd2, 32'h0,         32'hCAFEF00D, 0,  1'b1, 1'b0));
    xq.push_back(mkx(1'b0, 32'h0000_0400, 3'd2, 32'h0,         32'h11112222, 10, 1'b0, 1'b0));
    xq.push_back(mkx(1'b0, 32'h0001_0500, 3'd1, 32'h0,         32'h33334444, 0,  1'b0, 1'b1));
    xq.push_back(mkx(1'b1, 32'h0000_0600, 3'd0, 32'h55667788, 32'h0,        0,  1'b0, 1'b1));
    xq.push_back(mkx(1'b0, 32'h0000_0700, 3'd3, 32'h0,         32'h0,        0,  1'b0, 1'b0));
    run_queue();

    // Reset pulse during ACCESS.
    @(posedge hclk); #1;
    drive_addr(mkx(1'b0, 32'h0000_0ABC, 3'd2, 32'h0, 32'h0, 0, 1'b0, 1'b0));
    pready = 1'b0; prdata = 32'h7777_8888;
    @(negedge hclk); check_idle("rst_pre");
    @(posedge hclk); #1; drive_idle();
    @(negedge hclk); check({"rst_setup_psel"}, {31'h0, psel}, 32'h1);
    @(posedge hclk); #1;
    @(negedge hclk); check({"rst_access_penable"}, {31'h0, penable}, 32'h1);
    #1 hresetn = 1'b0;
    #1 check_reset("rst_mid");
    @(posedge hclk); #1 hresetn = 1'b1;
    xq.push_back(mkx(1'b0, 32'h0000_0ABC, 3'd2, 32'h0, 32'h0BADC0DE, 0, 1'b0, 1'b0));
    run_queue();

    // Random transfers.
    for (int n = 0; n < 80; n++) begin
      xq.push_back(mkx(1'($urandom_range(0, 1)), $urandom,
                       ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                                   : 3'($urandom_range(0, 2)),
                       $urandom, $urandom, int'($urandom_range(0, 5)),
                       ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1))));
    end
    run_queue();

    @(posedge hclk); #1 drive_idle();
    @(negedge hclk); check_idle("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
